// File: rtl/punc_control_pkg.sv
// Shared definitions for the PUnC LC3 controller and datapath: opcodes,
// datapath select encodings, controller state enum and sign-extension helpers.
package punc_control_pkg;

    // LC3 opcodes (ir[15:12])
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;

    // PC data select
    localparam logic PC_DATA_ADDER = 1'b0;
    localparam logic PC_DATA_ALU   = 1'b1;
    // PC adder offset select
    localparam logic PC_ADD_OFF11  = 1'b0;
    localparam logic PC_ADD_OFF9   = 1'b1;
    // Memory address select
    localparam logic [1:0] ADDR_PC    = 2'b00;
    localparam logic [1:0] ADDR_ALU   = 2'b01;
    localparam logic [1:0] ADDR_STORE = 2'b10;
    // Register-file write data select
    localparam logic [1:0] RF_DATA_PC  = 2'b00;
    localparam logic [1:0] RF_DATA_MEM = 2'b01;
    localparam logic [1:0] RF_DATA_ALU = 2'b10;
    // ALU operand selects
    localparam logic A_PC   = 1'b0;
    localparam logic A_RF   = 1'b1;
    localparam logic B_RF   = 1'b0;
    localparam logic B_SEXT = 1'b1;
    // ALU operations
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_AND    = 2'b01;
    localparam logic [1:0] ALU_PASS_A = 2'b10;
    localparam logic [1:0] ALU_NOT    = 2'b11;
    // Condition-flag source
    localparam logic NZP_ALU = 1'b0;
    localparam logic NZP_RF  = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_FETCH_WT = 3'd1,
        ST_FETCH    = 3'd2,
        ST_DECODE   = 3'd3,
        ST_EX1      = 3'd4,
        ST_EX2      = 3'd5,
        ST_EX3      = 3'd6,
        ST_HALT     = 3'd7
    } state_t;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    // Opcodes this datapath revision cannot execute (RTI, STI, reserved)
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == OP_RTI) || (op == OP_STI) || (op == OP_RES);
    endfunction

endpackage

// File: rtl/punc_decode.sv
// Combinational field decode of the instruction register: register
// addresses and the opcode-dependent sign-extended immediate.
module punc_decode
    import punc_control_pkg::*;
(
    input  logic [15:0] ir,
    output logic [15:0] sext_data,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2
);

    // Field extraction and immediate selection by opcode
    always_comb begin
        dr  = ir[11:9];
        sr1 = ir[8:6];
        sr2 = ir[2:0];
        case (ir[15:12])
            OP_LDR, OP_STR:               sext_data = sext6(ir[5:0]);
            OP_LD, OP_LDI, OP_ST, OP_LEA: sext_data = sext9(ir[8:0]);
            default:                      sext_data = sext5(ir[4:0]);
        endcase
    end

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: sequences fetch, decode and per-opcode execute steps
// and drives every datapath select, load and write enable.
// Optional macro PUNC_ILLEGAL_HALT_EN: illegal opcodes halt the processor and
// set a sticky 'illegal' output; otherwise they execute as a one-cycle no-op.
module punc_control
    import punc_control_pkg::*;
#(
    parameter int         FETCH_WAIT  = 0,
    parameter logic [3:0] HALT_OPCODE = 4'hF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic        pc_data_sel,
    output logic        pc_add_sel,
    output logic        ir_ld,
    output logic [1:0]  addr_mem_sel,
    output logic        w_en_mem,
    output logic [1:0]  w_rf_sel,
    output logic [2:0]  r_addr_0_rf,
    output logic [2:0]  r_addr_1_rf,
    output logic [2:0]  w_addr_rf,
    output logic        w_en_rf,
    output logic        a_sel,
    output logic        b_sel,
    output logic [15:0] sext_data,
    output logic [1:0]  alu_sel,
    output logic        nzp_sel,
    output logic        n_ld,
    output logic        z_ld,
    output logic        p_ld,
    output logic        store_ld,
`ifdef PUNC_ILLEGAL_HALT_EN
    output logic        illegal,
`endif
    output logic        halted
);

    localparam logic [2:0] WT_LAST = 3'(FETCH_WAIT - 1);

    state_t      state;
    logic [2:0]  wt_cnt;
    logic [3:0]  op;
    logic [15:0] dec_sext;
    logic [2:0]  dec_dr;
    logic [2:0]  dec_sr1;
    logic [2:0]  dec_sr2;
    logic        illegal_halt;

    assign op = ir[15:12];

    punc_decode u_decode (
        .ir        (ir),
        .sext_data (dec_sext),
        .dr        (dec_dr),
        .sr1       (dec_sr1),
        .sr2       (dec_sr2)
    );

`ifdef PUNC_ILLEGAL_HALT_EN
    logic illegal_seen;
    assign illegal_halt = is_illegal(op);

    // Sticky record that an illegal opcode stopped the processor
    always_ff @(posedge clk) begin
        if (!rst) begin
            illegal_seen <= 1'b0;
        end else if (state == ST_DECODE && op != HALT_OPCODE && is_illegal(op)) begin
            illegal_seen <= 1'b1;
        end else begin
            illegal_seen <= illegal_seen;
        end
    end

    assign illegal = illegal_seen & rst;
`else
    assign illegal_halt = 1'b0;
`endif

    // State register and fetch-wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_INIT;
            wt_cnt <= 3'd0;
        end else begin
            case (state)
                ST_INIT: begin
                    wt_cnt <= 3'd0;
                    state  <= (FETCH_WAIT > 0) ? ST_FETCH_WT : ST_FETCH;
                end
                ST_FETCH_WT: begin
                    if (wt_cnt == WT_LAST) begin
                        wt_cnt <= 3'd0;
                        state  <= ST_FETCH;
                    end else begin
                        wt_cnt <= wt_cnt + 3'd1;
                    end
                end
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    if (op == HALT_OPCODE || illegal_halt) begin
                        state <= ST_HALT;
                    end else begin
                        state <= ST_EX1;
                    end
                end
                ST_EX1: begin
                    if (op == OP_LD || op == OP_LDR || op == OP_LDI) begin
                        state <= ST_EX2;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_EX2: state <= (op == OP_LDI) ? ST_EX3 : ST_FETCH;
                ST_EX3: state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Datapath controls decoded from state and instruction; all zero in reset
    always_comb begin
        pc_ld        = 1'b0;
        pc_clr       = 1'b0;
        pc_inc       = 1'b0;
        pc_data_sel  = PC_DATA_ADDER;
        pc_add_sel   = PC_ADD_OFF11;
        ir_ld        = 1'b0;
        addr_mem_sel = ADDR_PC;
        w_en_mem     = 1'b0;
        w_rf_sel     = RF_DATA_PC;
        r_addr_0_rf  = 3'd0;
        r_addr_1_rf  = 3'd0;
        w_addr_rf    = 3'd0;
        w_en_rf      = 1'b0;
        a_sel        = A_PC;
        b_sel        = B_RF;
        sext_data    = 16'h0000;
        alu_sel      = ALU_ADD;
        nzp_sel      = NZP_ALU;
        n_ld         = 1'b0;
        z_ld         = 1'b0;
        p_ld         = 1'b0;
        store_ld     = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            case (state)
                ST_INIT:     pc_clr = 1'b1;
                ST_FETCH_WT: addr_mem_sel = ADDR_PC;
                ST_FETCH: begin
                    addr_mem_sel = ADDR_PC;
                    ir_ld        = 1'b1;
                    pc_inc       = 1'b1;
                end
                ST_EX1: begin
                    sext_data = dec_sext;
                    case (op)
                        OP_ADD, OP_AND, OP_NOT: begin
                            r_addr_0_rf = dec_sr1;
                            r_addr_1_rf = dec_sr2;
                            w_addr_rf   = dec_dr;
                            a_sel       = A_RF;
                            b_sel       = ir[5];
                            alu_sel     = (op == OP_ADD) ? ALU_ADD :
                                          ((op == OP_AND) ? ALU_AND : ALU_NOT);
                            w_rf_sel    = RF_DATA_ALU;
                            w_en_rf     = 1'b1;
                            nzp_sel     = NZP_ALU;
                            n_ld        = 1'b1;
                            z_ld        = 1'b1;
                            p_ld        = 1'b1;
                        end
                        OP_LEA: begin
                            a_sel     = A_PC;
                            b_sel     = B_SEXT;
                            alu_sel   = ALU_ADD;
                            w_rf_sel  = RF_DATA_ALU;
                            w_addr_rf = dec_dr;
                            w_en_rf   = 1'b1;
                        end
                        OP_BR: begin
                            pc_data_sel = PC_DATA_ADDER;
                            pc_add_sel  = PC_ADD_OFF9;
                            pc_ld       = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
                        end
                        OP_JMP: begin
                            r_addr_0_rf = dec_sr1;
                            a_sel       = A_RF;
                            alu_sel     = ALU_PASS_A;
                            pc_data_sel = PC_DATA_ALU;
                            pc_ld       = 1'b1;
                        end
                        OP_JSR: begin
                            // R7 is written with the incremented PC while the
                            // jump target (possibly old R7) is read the same cycle
                            w_addr_rf = 3'd7;
                            w_rf_sel  = RF_DATA_PC;
                            w_en_rf   = 1'b1;
                            pc_ld     = 1'b1;
                            if (ir[11]) begin
                                pc_data_sel = PC_DATA_ADDER;
                                pc_add_sel  = PC_ADD_OFF11;
                            end else begin
                                r_addr_0_rf = dec_sr1;
                                a_sel       = A_RF;
                                alu_sel     = ALU_PASS_A;
                                pc_data_sel = PC_DATA_ALU;
                            end
                        end
                        OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR: begin
                            // Effective address formed in the ALU: base + offset
                            if (op == OP_LDR || op == OP_STR) begin
                                r_addr_0_rf = dec_sr1;
                                a_sel       = A_RF;
                            end else begin
                                a_sel       = A_PC;
                            end
                            b_sel        = B_SEXT;
                            alu_sel      = ALU_ADD;
                            addr_mem_sel = ADDR_ALU;
                            if (op == OP_ST || op == OP_STR) begin
                                r_addr_1_rf = dec_dr;
                                w_en_mem    = 1'b1;
                            end else begin
                                w_rf_sel  = RF_DATA_MEM;
                                w_addr_rf = dec_dr;
                                w_en_rf   = 1'b1;
                            end
                        end
                        default: begin
                            pc_ld = 1'b0;
                        end
                    endcase
                end
                ST_EX2: begin
                    sext_data = dec_sext;
                    case (op)
                        OP_LD, OP_LDR: begin
                            r_addr_0_rf = dec_dr;
                            nzp_sel     = NZP_RF;
                            n_ld        = 1'b1;
                            z_ld        = 1'b1;
                            p_ld        = 1'b1;
                        end
                        OP_LDI: begin
                            // DR holds the pointer; use it as the final address
                            r_addr_0_rf  = dec_dr;
                            a_sel        = A_RF;
                            alu_sel      = ALU_PASS_A;
                            addr_mem_sel = ADDR_ALU;
                            w_rf_sel     = RF_DATA_MEM;
                            w_addr_rf    = dec_dr;
                            w_en_rf      = 1'b1;
                        end
                        default: begin
                            pc_ld = 1'b0;
                        end
                    endcase
                end
                ST_EX3: begin
                    sext_data   = dec_sext;
                    r_addr_0_rf = dec_dr;
                    nzp_sel     = NZP_RF;
                    n_ld        = 1'b1;
                    z_ld        = 1'b1;
                    p_ld        = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: pc_clr = 1'b0;
            endcase
        end else begin
            halted = 1'b0;
        end
    end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Control FSM for the PUnC LC3 processor. It is the controller end of the datapath control interface.
- Consumes the instruction register and the n/z/p condition flags from the datapath.
- Drives every datapath select, load and write-enable, sequencing fetch, decode and the per-opcode execute steps.
- Sits beside the datapath inside the PUnC top level. No memory or register-file storage of its own.

Parameters:
FETCH_WAIT, 0, extra cycles held in FETCH_WT before the IR load (memory latency padding, 0..7).
HALT_OPCODE, 4'hF, opcode that enters HALT.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
ir  in  16  datapath IR; valid from DECODE onward
n, z, p  in  1 each  datapath condition flags
pc_ld, pc_clr, pc_inc  out  1 each  PC load / clear / increment
pc_data_sel  out  1  0=PC+offset adder, 1=ALU result
pc_add_sel  out  1  0=offset11, 1=offset9
ir_ld  out  1  load IR from memory read port 0
addr_mem_sel  out  2  00=PC, 01=ALU, 10=store register
w_en_mem  out  1  memory write
w_rf_sel  out  2  00=PC, 01=mem data, 10=ALU
r_addr_0_rf, r_addr_1_rf, w_addr_rf  out  3 each  RF addresses
w_en_rf  out  1  RF write
a_sel  out  1  0=PC, 1=rf port 0
b_sel  out  1  0=rf port 1, 1=sext_data
sext_data  out  16  sign-extended imm5 / offset6 / offset9
alu_sel  out  2  00=ADD, 01=AND, 10=PASS_A, 11=NOT
nzp_sel  out  1  0=ALU result, 1=rf port 0
n_ld, z_ld, p_ld  out  1 each  flag updates; always asserted together
store_ld  out  1  latch ALU result into store register
halted  out  1  processor halted

Behaviour:
- States: INIT, FETCH_WT, FETCH, DECODE, EX1, EX2, EX3, HALT. State is registered; outputs are combinational from state and ir.
- Unlisted outputs are 0 in every state.
- Reset (rst==0 at a posedge):
  - Next state is INIT; the FETCH_WT counter is cleared.
  - While rst==0, all outputs are 0 and halted=0.
  - Reset mid-instruction abandons it with no further writes.
- INIT: pc_clr=1 -> FETCH_WT (FETCH_WAIT>0) or FETCH.
- FETCH_WT: counts FETCH_WAIT cycles with addr_mem_sel=00, then -> FETCH.
- FETCH: addr_mem_sel=00, ir_ld=1, pc_inc=1 -> DECODE.
- DECODE: no enables. HALT_OPCODE -> HALT; otherwise -> EX1.
- Field map: DR/SR=ir[11:9], SR1/BaseR=ir[8:6], SR2=ir[2:0].
  - sext_data = ir[5:0] sign-extended (LDR, STR), ir[8:0] sign-extended (LD, LDI, ST, LEA), else ir[4:0] sign-extended.
- ADD(0001) / AND(0101):
  - EX1: a_sel=1, b_sel=ir[5], alu ADD/AND, w_rf_sel=10, w_en_rf, flags with nzp_sel=0 -> FETCH.
- NOT(1001): EX1 as ADD but alu NOT -> FETCH.
- LEA(1110): EX1: a_sel=0, b_sel=1, ADD, w_rf_sel=10, w_en_rf. Flags unchanged -> FETCH.
- BR(0000): EX1: pc_ld=1 (pc_data_sel=0, pc_add_sel=1) iff (ir[11]&n)|(ir[10]&z)|(ir[9]&p) -> FETCH.
  - nzp=000 or an unmatched condition is a no-op.
- JMP(1100): EX1: r_addr_0=BaseR, a_sel=1, PASS_A, pc_data_sel=1, pc_ld -> FETCH.
- JSR/JSRR(0100), single cycle EX1:
  - w_addr=7, w_rf_sel=00, w_en_rf.
  - Same cycle pc_ld: ir[11] ? (pc_data_sel=0, pc_add_sel=0) : (PASS_A BaseR, pc_data_sel=1).
  - JSRR R7 uses the pre-write R7 value.
- LD(0010) / LDR(0110):
  - EX1: address = PC+sext9 or BaseR+sext6 via ALU, addr_mem_sel=01, w_rf_sel=01, w_en_rf.
  - EX2: r_addr_0=DR, nzp_sel=1, flags -> FETCH.
- LDI(1010):
  - EX1: as LD, writing DR.
  - EX2: r_addr_0=DR, PASS_A, addr_mem_sel=01, w_rf_sel=01, w_en_rf.
  - EX3: flags from DR -> FETCH.
- ST(0011) / STR(0111): EX1: address as LD/LDR, addr_mem_sel=01, r_addr_1=SR, w_en_mem -> FETCH.
- Illegal opcodes (1000, 1011 STI, 1101): see Optional Feature. STI is unsupported by this datapath revision.
- HALT: halted=1, no enables; held until reset.
- The PC observed by EX states is already incremented.

Optional Feature:
- Macro PUNC_ILLEGAL_HALT_EN.
- Defined: an illegal opcode in DECODE -> HALT, and output illegal (1 bit, reset 0) is set sticky until reset.
- Undefined: illegal opcodes execute as a 1-cycle no-op EX1 -> FETCH; no illegal port.

Decomposition:
- Shared package holds:
  - opcode constants;
  - all select encodings (PC/ALU/MEM data, addr select, ALU ops, nzp select);
  - the state enum.
- The datapath imports the same package.
- One natural sub-module: punc_decode, a combinational mapping of opcode and field to sext_data and register addresses.

Test Plan:
- Reset, then release with mem[0]=0x1262 (ADD R1,R1,#2): INIT asserts pc_clr; FETCH at cycle 2; EX1 at cycle 4 with w_en_rf=1, w_addr=1, b_sel=1, sext_data=0x0002, n/z/p_ld=1.
- BRz (0x0403) with z=1 -> EX1 pc_ld=1, pc_add_sel=1, sext_data irrelevant. With z=0 -> pc_ld=0, next state FETCH.
- JSRR R7 (0x41C0) -> single EX1 with w_addr=7, w_en_rf=1, pc_data_sel=1, alu_sel=10, r_addr_0=7.
- LDI R2 (0xA401) -> EX1, EX2 (addr_mem_sel=01, w_rf_sel=01), EX3 (nzp_sel=1, r_addr_0=2), then FETCH; 5 cycles in total.
- 0xF025 -> DECODE then HALT, halted=1 forever. rst low during EX2 of an LDR -> INIT with no w_en_rf in the following cycle.
- 0xD000: with PUNC_ILLEGAL_HALT_EN -> HALT, illegal=1. Without it -> one no-op EX1, then FETCH with pc_inc=1.
